// File: rtl/lc3b_types.sv
// Shared types for the cache-to-physical-memory line interface.
// Line width, op encoding and responder FSM states.
package lc3b_types;

  localparam int LC3B_LINE_OFFSET_BITS = 4;

  typedef logic [127:0] lc3b_c_line;

  typedef enum logic {
    PMEM_RD,
    PMEM_WR
  } lc3b_pmem_op;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } pmem_state_t;

endpackage

// File: rtl/pmem_line_responder_array.sv
// Line-granular backing store: synchronous write, combinational read.
// Contents survive reset.
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int unsigned INDEX_BITS = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] windex,
  input  lc3b_c_line            wdata,
  input  logic [INDEX_BITS-1:0] rindex,
  output lc3b_c_line            rdata
);

  lc3b_c_line mem [2**INDEX_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[windex] <= wdata;
  end

  assign rdata = mem[rindex];

endmodule

// File: rtl/pmem_line_responder.sv
// Physical-memory line responder: accepts one line read/write at a time
// and answers with a single-cycle pmem_resp after a fixed latency.
module pmem_line_responder
  import lc3b_types::*;
#(
  parameter int unsigned INDEX_BITS    = 8,
  parameter int unsigned READ_LATENCY  = 4,
  parameter int unsigned WRITE_LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         busy,
  output logic         proto_err
);

  localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

  pmem_state_t           state, state_d;
  logic [3:0]            cnt, cnt_d;
  lc3b_pmem_op           op;
  logic [INDEX_BITS-1:0] index;
  lc3b_c_line            wdata_q;
  lc3b_c_line            line;
  logic                  accept;
  logic                  err_set;
  logic                  we;
  logic [1:0]            rst_sync;
  logic                  srst_n;
  logic                  unused_addr;

  // Offset and alias bits above the index are intentionally dropped.
  assign unused_addr = ^pmem_address;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign srst_n = rst_sync[1];

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= PMEM_RD;
      index     <= '0;
      wdata_q   <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (err_set) proto_err <= 1'b1;
      if (accept) begin
        op      <= pmem_read ? PMEM_RD : PMEM_WR;
        index   <= pmem_address[LC3B_LINE_OFFSET_BITS +: INDEX_BITS];
        wdata_q <= pmem_wdata;
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    err_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (pmem_read) begin
          accept  = 1'b1;
          err_set = pmem_write;
          cnt_d   = RD_LOAD;
          state_d = (READ_LATENCY == 1) ? RESP : BUSY;
        end else if (pmem_write) begin
          accept  = 1'b1;
          cnt_d   = WR_LOAD;
          state_d = (WRITE_LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d   = cnt - 4'd1;
        err_set = (op == PMEM_RD) ? !pmem_read : !pmem_write;
        if (cnt == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Writes commit only on the edge closing RESP, so reset aborts them.
  assign we         = (state == RESP) && (op == PMEM_WR);
  assign pmem_resp  = (state == RESP);
  assign busy       = (state != IDLE);
  assign pmem_rdata = (state == RESP && op == PMEM_RD) ? line : '0;

  pmem_line_array #(
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .windex(index),
    .wdata (wdata_q),
    .rindex(index),
    .rdata (line)
  );

endmodule

// File: tb/tb_pmem_line_responder.sv
// Scoreboard bench for pmem_line_responder with a line-map reference model.
// A second instance exercises single-cycle read latency.
module tb_pmem_line_responder;
  import lc3b_types::*;

  localparam int RL = 4;
  localparam int WL = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pmem_read = 1'b0;
  logic         pmem_write = 1'b0;
  logic [15:0]  pmem_address = '0;
  logic [127:0] pmem_wdata = '0;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         busy;
  logic         proto_err;

  logic         l1_read = 1'b0;
  logic         l1_resp;
  logic [127:0] l1_rdata;
  logic         l1_busy;
  logic         l1_err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int           due;
    logic [127:0] data;
  } exp_t;

  exp_t         sb [$];
  logic [127:0] model [int];

  pmem_line_responder #(
    .INDEX_BITS(8), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata), .busy(busy), .proto_err(proto_err)
  );

  pmem_line_responder #(
    .INDEX_BITS(8), .READ_LATENCY(1), .WRITE_LATENCY(2)
  ) dut_l1 (
    .clk(clk), .rst_n(rst_n), .pmem_read(l1_read),
    .pmem_write(1'b0), .pmem_address(16'h0010),
    .pmem_wdata(128'h0), .pmem_resp(l1_resp),
    .pmem_rdata(l1_rdata), .busy(l1_busy), .proto_err(l1_err)
  );

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (pmem_resp) begin
        check("resp_expected", 128'(sb.size() > 0), 128'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("resp_cycle", 128'(cyc), 128'(e.due));
          check("resp_rdata", pmem_rdata, e.data);
        end
      end else begin
        check("rdata_idle_zero", pmem_rdata, 128'h0);
        if (sb.size() > 0 && cyc > sb[0].due) begin
          void'(sb.pop_front());
          check("resp_missing", 128'(pmem_resp), 128'(1));
        end
      end
    end
  end

  task automatic transact(input logic rd, input logic wr,
                          input logic [15:0] addr,
                          input logic [127:0] wd, input bit drop);
    int   idx;
    bit   got;
    exp_t e;
    @(posedge clk);
    #1;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wd;
    idx = int'(addr[11:4]);
    if (rd) begin
      e.due  = cyc + RL;
      e.data = model[idx];
    end else begin
      model[idx] = wd;
      e.due  = cyc + WL;
      e.data = '0;
    end
    sb.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      check("busy", 128'(busy), 128'(k > 0));
      if (drop && k == 2) begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
      got = pmem_resp;
    end
    if (!got) check("handshake_timeout", 128'(pmem_resp), 128'(1));
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int           idx;
    int           t;
    logic         rd;
    logic [15:0]  addr;
    logic [127:0] data;

    repeat (3) @(negedge clk);
    check("rst_resp", 128'(pmem_resp), 128'(0));
    check("rst_rdata", pmem_rdata, 128'h0);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_proto_err", 128'(proto_err), 128'(0));
    rst_n = 1'b1;
    repeat (3) idle();

    transact(0, 1, 16'h0120, 128'h0123456789ABCDEF0123456789ABCDEF, 0);
    idle();
    transact(1, 0, 16'h0120, '0, 0);
    idle();

    transact(0, 1, 16'h0340, {32{4'hA}}, 0);
    transact(1, 0, 16'h0348, '0, 0);
    idle();

    transact(0, 1, 16'h0600, 128'h600D_0600, 0);
    idle();
    transact(0, 1, 16'h0500, 128'h0500_BEEF, 0);
    transact(1, 0, 16'h0600, '0, 0);
    idle();
    check("b2b_proto_err", 128'(proto_err), 128'(0));

    repeat (60) begin
      idx  = int'($urandom_range(0, 15));
      addr = {4'($urandom), 8'(idx), 4'($urandom)};
      rd   = model.exists(idx) && ($urandom_range(0, 1) == 1);
      data = {$urandom, $urandom, $urandom, $urandom};
      transact(rd, !rd, addr, data, 0);
      repeat ($urandom_range(0, 2)) idle();
    end
    idle();
    check("rand_proto_err", 128'(proto_err), 128'(0));

    transact(1, 1, 16'h0124, 128'hDEAD_DEAD, 0);
    idle();
    check("both_proto_err", 128'(proto_err), 128'(1));
    transact(1, 0, 16'h0120, '0, 0);
    idle();
    transact(1, 0, 16'h0340, '0, 1);
    idle();
    check("drop_proto_err", 128'(proto_err), 128'(1));

    transact(0, 1, 16'h0700, {32{4'h5}}, 0);
    idle();
    @(posedge clk);
    #1;
    pmem_write   = 1'b1;
    pmem_address = 16'h0700;
    pmem_wdata   = {128{1'b1}};
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_resp", 128'(pmem_resp), 128'(0));
    check("abort_rdata", pmem_rdata, 128'h0);
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_proto_err", 128'(proto_err), 128'(0));
    pmem_write = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_no_resp", 128'(pmem_resp), 128'(0));
    rst_n = 1'b1;
    repeat (3) idle();
    transact(1, 0, 16'h0700, '0, 0);
    idle();

    @(posedge clk);
    #1;
    l1_read = 1'b1;
    t = cyc;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      check("lat1_resp", 128'(l1_resp), 128'((cyc - t) % 2 == 1));
    end
    l1_read = 1'b0;
    repeat (2) @(negedge clk);
    check("lat1_proto_err", 128'(l1_err), 128'(0));
    check("sb_drained", 128'(sb.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pmem_line_responder.md
Name: pmem_line_responder

Overview:
- Responder end of the cache-to-physical-memory line interface: services `pmem_read` / `pmem_write` requests from a cache controller and answers each with a single-cycle `pmem_resp`.
- Holds a line-granular backing store with programmable access latency.
- Used as the physical memory behind the instruction and data caches in simulation and FPGA builds.
- Transfers whole 128-bit lines, addressed by line.

Parameters:
- INDEX_BITS, 8, number of line-index bits; store depth is 2**INDEX_BITS lines.
- READ_LATENCY, 4, cycles from request acceptance to `pmem_resp` for reads; legal range 1..15.
- WRITE_LATENCY, 4, same for writes; legal range 1..15.

Ports:
- clk, in, 1, system clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- pmem_read, in, 1, line read request; level, held until `pmem_resp`.
- pmem_write, in, 1, line write request; level, held until `pmem_resp`.
- pmem_address, in, 16, byte address; bits [3:0] ignored.
- pmem_wdata, in, 128, write line.
- pmem_resp, out, 1, one-cycle completion pulse.
- pmem_rdata, out, 128, read line; valid only in the `pmem_resp` cycle of a read.
- busy, out, 1, high in BUSY and RESP.
- proto_err, out, 1, sticky protocol-violation flag.

Behaviour:
- Reset (async assert, sync deassert internally): state=IDLE; `pmem_resp`=0, `pmem_rdata`=0, `busy`=0, `proto_err`=0; latency counter=0.
- Store contents are not cleared by reset.
- Index = `pmem_address[4+INDEX_BITS-1:4]`; higher address bits are ignored, so addresses alias.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If `pmem_read` or `pmem_write` is high, accept. Capture op, index and `pmem_wdata`; load counter with LATENCY-1 for that op.
  - Go to RESP if LATENCY==1, else to BUSY.
  - With no request, stay in IDLE.
- BUSY: decrement counter each cycle; go to RESP when the counter reaches 1.
- RESP:
  - `pmem_resp`=1 for exactly one cycle.
  - Read: `pmem_rdata` = store[captured index] during this cycle.
  - Write: store[captured index] <= captured wdata at the end of this cycle.
  - Next state is always IDLE.
- Latency: a request first seen high in cycle t (IDLE) gets `pmem_resp` in cycle t+LATENCY.
- Back-to-back requests:
  - A request present in the cycle after RESP is treated as a new request and accepted normally. This supports the write-back-then-fill sequence, where `pmem_read` rises the cycle after a write's `pmem_resp`.
  - The request still high during the RESP cycle is never re-accepted.
- Simultaneous `pmem_read` and `pmem_write` at acceptance: read wins and `proto_err` is set.
- Request deasserted while in BUSY: the transaction still completes and pulses `pmem_resp`; `proto_err` is set.
- `pmem_address` or `pmem_wdata` changing during BUSY is ignored, because captured values are used.
- Reset during BUSY or RESP:
  - The transaction is aborted with no store write and no `pmem_resp`.
  - A write is committed only at the RESP edge, so a write aborted by reset never reaches the store.
- `pmem_rdata` is 0 outside a read RESP cycle.
- `proto_err` clears only on reset.

Decomposition:
- Add to lc3b_types:
  - `lc3b_c_line` (128-bit).
  - `lc3b_pmem_op` enum {PMEM_RD, PMEM_WR}.
  - A constant `LC3B_LINE_OFFSET_BITS` = 4.
- Sub-module `pmem_line_array`: synchronous-write, combinational-read array of 2**INDEX_BITS lines, with ports clk, we, windex, wdata, rindex, rdata. It has no reset.
- The FSM and counter live in the top module.

Test Plan:
- Read latency and data: preload line 0x12 = 0x0123…CDEF; hold `pmem_read` with address 0x0120 at cycle 10 -> `pmem_resp` only in cycle 14, `pmem_rdata`=preloaded line, `busy` high cycles 11-14.
- Write then read: write 0xAAAA…AAAA to 0x0340, then read 0x0348 -> read returns 0xAAAA…AAAA; offset bits are ignored.
- Back-to-back: `pmem_write` to 0x0500; on its resp cycle+1 switch to `pmem_read` of 0x0600 -> second resp exactly 4 cycles later; exactly one resp per request; `proto_err`=0.
- Latency 1 (READ_LATENCY=1): request in cycle t -> resp in cycle t+1; continuous `pmem_read` of 0x0010 yields resp every 2 cycles.
- Protocol errors: assert read and write together -> read performed, store unchanged, `proto_err`=1. Drop `pmem_read` mid-BUSY -> resp still pulses and `proto_err` stays 1.
- Reset mid-write: start write of 0xFFFF…F to 0x0700, pull `rst_n` low in cycle 2 of BUSY -> outputs 0 immediately, no resp, and a later read of 0x0700 returns the old line.
